key_loader: RTL and testbench

//   Upstream feeder for the key expansion stage. Collects a cipher key as NK words

---
 rtl/key_loader.sv | 143 ++++++++++++++
 tb/tb_key_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_loader.sv
// Cipher key collector: assembles NK words from a valid/ready stream, commits
// them to o_key, then times a settle window before flagging round keys usable.
module key_loader #(
    parameter int unsigned WORD   = 32,
    parameter int unsigned NK     = 4,
    parameter int unsigned SETTLE = 108
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WORD-1:0]      s_data,
    input  logic                 s_last,
    output logic [WORD*NK-1:0]   o_key,
    output logic                 o_valid,
    output logic                 o_keys_ready,
    output logic                 o_err
);

    localparam int unsigned KW = WORD * NK;
    localparam int unsigned CW = $clog2(NK + 1);
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMMIT,
        ST_SETTLE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [SW-1:0]   scnt, scnt_nxt;
    logic [WORD-1:0] kbuf     [NK];
    logic [WORD-1:0] kbuf_nxt [NK];
    logic [KW-1:0]   key_nxt;
    logic [KW-1:0]   assembled;
    logic            valid_nxt, ready_nxt, err_nxt;
    logic            beat, last_slot, good, bad, final_beat;

    // Ready depends only on registered state so it never loops back through s_valid.
    assign s_ready    = (cnt < CW'(NK)) && (state != ST_COMMIT);
    assign beat       = s_valid && s_ready;
    assign last_slot  = (cnt == CW'(NK - 1));
    assign good       = beat && (s_last == last_slot);
    assign bad        = beat && (s_last != last_slot);
    assign final_beat = good && last_slot;

    // Key image as it would look if committed this cycle (final beat bypasses the buffer).
    always_comb begin
        assembled = '0;
        for (int i = 0; i < int'(NK); i++) begin
            assembled[(int'(NK) - 1 - i) * int'(WORD) +: WORD] = kbuf[i];
        end
        if (final_beat) begin
            assembled[WORD-1:0] = s_data;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        scnt_nxt  = scnt;
        kbuf_nxt  = kbuf;
        key_nxt   = o_key;
        valid_nxt = 1'b0;
        ready_nxt = o_keys_ready;
        err_nxt   = 1'b0;

        if (good) begin
            for (int i = 0; i < int'(NK); i++) begin
                if (cnt == CW'(i)) begin
                    kbuf_nxt[i] = s_data;
                end
            end
            cnt_nxt = cnt + CW'(1);
        end
        if (bad) begin
            cnt_nxt = '0;
            err_nxt = 1'b1;
        end

        case (state)
            ST_LOAD: begin
                if ((cnt == CW'(NK)) || final_beat) begin
                    state_nxt = ST_COMMIT;
                    key_nxt   = assembled;
                    cnt_nxt   = '0;
                    ready_nxt = 1'b0;
                    valid_nxt = 1'b1;
                end
            end
            ST_COMMIT: begin
                if (SETTLE > 0) begin
                    state_nxt = ST_SETTLE;
                    scnt_nxt  = SW'(SETTLE - 1);
                end else begin
                    state_nxt = ST_LOAD;
                    ready_nxt = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (scnt == '0) begin
                    state_nxt = ST_LOAD;
                    ready_nxt = 1'b1;
                end else begin
                    scnt_nxt = scnt - SW'(1);
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    // State and output registers; reset wins over any beat in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_LOAD;
            cnt          <= '0;
            scnt         <= '0;
            o_key        <= '0;
            o_valid      <= 1'b0;
            o_keys_ready <= 1'b0;
            o_err        <= 1'b0;
            for (int i = 0; i < int'(NK); i++) begin
                kbuf[i] <= '0;
            end
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            scnt         <= scnt_nxt;
            o_key        <= key_nxt;
            o_valid      <= valid_nxt;
            o_keys_ready <= ready_nxt;
            o_err        <= err_nxt;
            for (int i = 0; i < int'(NK); i++) begin
                kbuf[i] <= kbuf_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader: AES-128 instance with settle window and an
// AES-256 instance with no settle window, checked against a key scoreboard.
module tb_key_loader;

    localparam int unsigned SETTLE_A = 108;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         a_valid = 1'b0, a_last = 1'b0;
    logic [31:0]  a_data = '0;
    logic         a_ready, a_ov, a_kr, a_err;
    logic [127:0] a_key;

    logic         b_valid = 1'b0, b_last = 1'b0;
    logic [31:0]  b_data = '0;
    logic         b_ready, b_ov, b_kr, b_err;
    logic [255:0] b_key;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [127:0] qa [$];
    logic [255:0] qb [$];

    key_loader #(.WORD(32), .NK(4), .SETTLE(SETTLE_A)) dut_a (
        .clk(clk), .rst(rst),
        .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data), .s_last(a_last),
        .o_key(a_key), .o_valid(a_ov), .o_keys_ready(a_kr), .o_err(a_err)
    );

    key_loader #(.WORD(32), .NK(8), .SETTLE(0)) dut_b (
        .clk(clk), .rst(rst),
        .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data), .s_last(b_last),
        .o_key(b_key), .o_valid(b_ov), .o_keys_ready(b_kr), .o_err(b_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [31:0] w, input logic last);
        int n;
        n = 0;
        a_valid = 1'b1;
        a_data  = w;
        a_last  = last;
        while (!a_ready && n < 500) begin
            step();
            n++;
        end
        if (n == 500) chk("a_accept_timeout", 256'(a_ready), 256'(1));
        step();
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] w, input logic last);
        int n;
        n = 0;
        repeat ($urandom_range(0, 2)) step();
        b_valid = 1'b1;
        b_data  = w;
        b_last  = last;
        while (!b_ready && n < 500) begin
            step();
            n++;
        end
        if (n == 500) chk("b_accept_timeout", 256'(b_ready), 256'(1));
        step();
        b_valid = 1'b0;
        b_last  = 1'b0;
    endtask

    task automatic send_key_a(input logic [127:0] k);
        qa.push_back(k);
        for (int i = 0; i < 4; i++) begin
            send_a(k[127 - 32*i -: 32], i == 3);
        end
    endtask

    task automatic check_commit_a(input string tag);
        logic [127:0] exp;
        exp = qa.pop_front();
        chk({tag, "_ov"}, 256'(a_ov), 256'(1));
        chk({tag, "_key"}, 256'(a_key), 256'(exp));
        chk({tag, "_kr_low"}, 256'(a_kr), 256'(0));
    endtask

    task automatic wait_kr_a();
        int n;
        n = 0;
        while (!a_kr && n < 300) begin
            step();
            n++;
        end
        chk("a_kr_wait", 256'(a_kr), 256'(1));
    endtask

    initial begin
        logic [127:0] key1, key2, key_a, key_b, key_r;
        logic [255:0] kb;
        int t0;

        key1  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        key2  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        key_a = 128'ha0a1a2a3_b0b1b2b3_c0c1c2c3_d0d1d2d3;
        key_b = 128'h11112222_33334444_55556666_77778888;
        key_r = 128'hdeadbeef_cafef00d_01234567_89abcdef;

        // Reset state
        rst = 1'b0;
        step();
        step();
        chk("rst_a_key", 256'(a_key), 256'(0));
        chk("rst_a_ov", 256'(a_ov), 256'(0));
        chk("rst_a_kr", 256'(a_kr), 256'(0));
        chk("rst_a_err", 256'(a_err), 256'(0));
        chk("rst_a_ready", 256'(a_ready), 256'(1));
        chk("rst_b_key", b_key, 256'(0));
        chk("rst_b_ready", 256'(b_ready), 256'(1));
        rst = 1'b1;
        step();

        // 1: FIPS-197 key, settle timing
        send_key_a(key1);
        t0 = cyc;
        check_commit_a("t1");
        step();
        chk("t1_ov_drop", 256'(a_ov), 256'(0));
        repeat (SETTLE_A - 1) step();
        chk("t1_kr_before", 256'(a_kr), 256'(0));
        step();
        chk("t1_kr_at", 256'(a_kr), 256'(1));
        chk("t1_kr_latency", 256'(cyc - t0), 256'(SETTLE_A + 1));

        // 2: early s_last then a good key
        send_a(32'h11111111, 1'b0);
        send_a(32'h22222222, 1'b1);
        chk("t2_err", 256'(a_err), 256'(1));
        chk("t2_no_ov", 256'(a_ov), 256'(0));
        chk("t2_key_kept", 256'(a_key), 256'(key1));
        step();
        chk("t2_err_pulse", 256'(a_err), 256'(0));
        send_key_a(key2);
        check_commit_a("t2");
        wait_kr_a();

        // 3: missing s_last on final word
        for (int i = 0; i < 4; i++) send_a(32'h33330000 + 32'(i), 1'b0);
        chk("t3_err", 256'(a_err), 256'(1));
        chk("t3_no_ov", 256'(a_ov), 256'(0));
        chk("t3_key_kept", 256'(a_key), 256'(key2));
        step();
        chk("t3_err_pulse", 256'(a_err), 256'(0));
        chk("t3_no_ov_late", 256'(a_ov), 256'(0));

        // 4: key B buffered during key A settle
        send_key_a(key_a);
        t0 = cyc;
        check_commit_a("t4a");
        send_key_a(key_b);
        chk("t4_ready_full", 256'(a_ready), 256'(0));
        chk("t4_key_held", 256'(a_key), 256'(key_a));
        chk("t4_kr_low", 256'(a_kr), 256'(0));
        wait_kr_a();
        chk("t4_kr_latency", 256'(cyc - t0), 256'(SETTLE_A + 1));
        step();
        check_commit_a("t4b");
        wait_kr_a();

        // 5: NK=8, SETTLE=0, random gaps
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) kb[255 - 32*i -: 32] = $urandom;
            qb.push_back(kb);
            for (int i = 0; i < 8; i++) send_b(kb[255 - 32*i -: 32], i == 7);
            chk("t5_ov", 256'(b_ov), 256'(1));
            chk("t5_key", b_key, qb.pop_front());
            chk("t5_err", 256'(b_err), 256'(0));
            step();
            chk("t5_kr", 256'(b_kr), 256'(1));
            chk("t5_ov_drop", 256'(b_ov), 256'(0));
        end

        // 6: reset mid-key then mid-settle
        send_a(32'h44444444, 1'b0);
        send_a(32'h55555555, 1'b0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t6a_key", 256'(a_key), 256'(0));
        chk("t6a_kr", 256'(a_kr), 256'(0));
        chk("t6a_ov", 256'(a_ov), 256'(0));
        chk("t6a_err", 256'(a_err), 256'(0));
        chk("t6a_ready", 256'(a_ready), 256'(1));
        send_key_a(key_r);
        check_commit_a("t6a");
        repeat (5) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t6b_key", 256'(a_key), 256'(0));
        chk("t6b_kr", 256'(a_kr), 256'(0));
        chk("t6b_ov", 256'(a_ov), 256'(0));
        chk("t6b_ready", 256'(a_ready), 256'(1));
        send_key_a(key1);
        t0 = cyc;
        check_commit_a("t6b");
        wait_kr_a();
        chk("t6b_kr_latency", 256'(cyc - t0), 256'(SETTLE_A + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
